// File: rtl/gru_seq_controller.sv
// gru_seq_controller: steps one gru_cell_parallel instance through an input sequence.
// Optional watchdog: define GRU_SEQ_WDOG_EN to abort a step whose cell never returns done.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   seq_start, seq_len     start request and length (sampled in IDLE only, clipped to MAX_T)
//   h_init                 initial hidden state, latched on accepted start
//   x_rd_en, x_rd_addr     feature buffer read strobe and timestep address
//   cell_start, cell_done  cell handshake (1-cycle pulses)
//   cell_h_t               cell output, captured when cell_done is seen in WAIT
//   h_prev                 hidden-state register feeding the cell
//   step_idx, busy         current timestep, sequence in progress
//   seq_done, seq_err      completion pulse, watchdog abort pulse
module gru_seq_controller #(
    parameter int H          = 16,
    parameter int DATA_WIDTH = 15,
    parameter int MAX_T      = 32,
    parameter int T_W        = $clog2(MAX_T + 1)
`ifdef GRU_SEQ_WDOG_EN
    , parameter int WDOG_CYCLES = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    seq_start,
    input  logic [T_W-1:0]          seq_len,
    input  logic [H*DATA_WIDTH-1:0] h_init,
    output logic                    x_rd_en,
    output logic [T_W-1:0]          x_rd_addr,
    output logic                    cell_start,
    input  logic                    cell_done,
    input  logic [H*DATA_WIDTH-1:0] cell_h_t,
    output logic [H*DATA_WIDTH-1:0] h_prev,
    output logic [T_W-1:0]          step_idx,
    output logic                    busy,
    output logic                    seq_done,
    output logic                    seq_err
);
    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, UPDATE, FINISH} state_t;

    state_t                  state, state_n;
    logic [T_W-1:0]          len_q;
    logic [H*DATA_WIDTH-1:0] h_stage;
    logic                    accept, last, abort;

    assign accept    = state == IDLE && seq_start;
    assign last      = step_idx == len_q - T_W'(1);
    // The address is the step register itself, so it stays put from FETCH through WAIT.
    assign x_rd_addr = step_idx;

`ifdef GRU_SEQ_WDOG_EN
    logic [15:0] wdog_cnt;
    // Counts cycles since cell_start: the first WAIT cycle already reads 1.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wdog_cnt <= '0;
        else        wdog_cnt <= (state == WAIT) ? wdog_cnt + 16'd1 : 16'd1;
    assign abort = state == WAIT && !cell_done && wdog_cnt == 16'(WDOG_CYCLES - 1);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (seq_start) state_n = (seq_len == '0) ? FINISH : FETCH;
            FETCH:   state_n = START;
            START:   state_n = WAIT;
            WAIT:    state_n = cell_done ? UPDATE : abort ? IDLE : WAIT;
            UPDATE:  state_n = last ? FINISH : FETCH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_rd_en    <= 1'b0;
            cell_start <= 1'b0;
            busy       <= 1'b0;
            seq_done   <= 1'b0;
            seq_err    <= 1'b0;
            len_q      <= '0;
            step_idx   <= '0;
            h_prev     <= '0;
            h_stage    <= '0;
        end else begin
            // Strobes follow the next state so they line up with the state they belong to;
            // seq_done trails FINISH by one cycle.
            x_rd_en    <= state_n == FETCH;
            cell_start <= state_n == START;
            busy       <= state_n != IDLE;
            seq_done   <= state == FINISH;
            seq_err    <= abort;
            if (accept) begin
                len_q    <= (seq_len > T_W'(MAX_T)) ? T_W'(MAX_T) : seq_len;
                step_idx <= '0;
                h_prev   <= h_init;
            end
            if (state == WAIT && cell_done) h_stage <= cell_h_t;
            if (state == UPDATE) begin
                h_prev <= h_stage;
                if (!last) step_idx <= step_idx + T_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_gru_seq_controller.sv
// tb_gru_seq_controller: directed self-checking bench for gru_seq_controller with a fake cell.
// The fake cell answers cell_start after cell_lat cycles with h_prev+1 per word; it can also
// inject a garbage done pulse (spur) or stay silent (cell_en=0).
module tb_gru_seq_controller;
    localparam int H     = 16;
    localparam int DW    = 15;
    localparam int MAX_T = 32;
    localparam int T_W   = $clog2(MAX_T + 1);
    localparam int HW    = H * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           seq_start = 1'b0;
    logic [T_W-1:0] seq_len = '0;
    logic [HW-1:0]  h_init = '0;
    logic           cell_done = 1'b0;
    logic [HW-1:0]  cell_h_t = '0;
    logic           x_rd_en, cell_start, busy, seq_done, seq_err;
    logic [T_W-1:0] x_rd_addr, step_idx;
    logic [HW-1:0]  h_prev;
    logic           cell_en = 1'b1;
    logic           spur = 1'b0;
    int             cell_lat = 5;
    int             n_checks = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    gru_seq_controller #(
        .H(H), .DATA_WIDTH(DW), .MAX_T(MAX_T), .T_W(T_W)
`ifdef GRU_SEQ_WDOG_EN
        , .WDOG_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .seq_start(seq_start), .seq_len(seq_len), .h_init(h_init),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .cell_start(cell_start), .cell_done(cell_done),
        .cell_h_t(cell_h_t), .h_prev(h_prev), .step_idx(step_idx), .busy(busy),
        .seq_done(seq_done), .seq_err(seq_err)
    );

    function automatic logic [HW-1:0] inc(input logic [HW-1:0] h);
        logic [HW-1:0] r;
        for (int i = 0; i < H; i++) r[i*DW +: DW] = h[i*DW +: DW] + DW'(1);
        return r;
    endfunction

    // Fake cell: reads inputs 1 time unit after the falling edge so it sees stimulus set there.
    initial begin
        int pend;
        pend = 0;
        forever begin
            @(negedge clk);
            #1;
            cell_done = 1'b0;
            if (spur) begin
                cell_done = 1'b1;
                cell_h_t  = {H{15'h7fff}};
            end
            if (pend == 1) begin
                cell_done = 1'b1;
                cell_h_t  = inc(h_prev);
            end
            if (pend > 0) pend--;
            if (rst_n && cell_start && cell_en) pend = cell_lat;
            if (!rst_n) pend = 0;
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({x_rd_en, cell_start, busy, seq_done, seq_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {x_rd_en, cell_start, busy, seq_done, seq_err});
        end
        n_checks++;
        if (h_prev !== '0) begin n_fail++; $display("FAIL reset_h_prev: got %h expected 0", h_prev); end
        n_checks++;
        if (step_idx !== '0) begin n_fail++; $display("FAIL reset_step_idx: got %0d expected 0", step_idx); end
        n_checks++;
        if (x_rd_addr !== '0) begin n_fail++; $display("FAIL reset_x_rd_addr: got %0d expected 0", x_rd_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [T_W-1:0] addrs[$];
        int n_st = 0, n_dn = 0, dn_k = -1;
        seq_len = 3; h_init = '0; cell_lat = 5; seq_start = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            seq_start = 1'b0;
            if (x_rd_en) addrs.push_back(x_rd_addr);
            if (cell_start) n_st++;
            if (seq_done) begin n_dn++; dn_k = k; end
        end
        n_checks++;
        if (addrs.size() !== 3) begin n_fail++; $display("FAIL basic_reads: got %0d expected 3", addrs.size()); end
        foreach (addrs[i]) begin
            n_checks++;
            if (addrs[i] !== T_W'(i)) begin n_fail++; $display("FAIL basic_addr%0d: got %0d expected %0d", i, addrs[i], i); end
        end
        n_checks++;
        if (n_st !== 3) begin n_fail++; $display("FAIL basic_starts: got %0d expected 3", n_st); end
        n_checks++;
        if (n_dn !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", n_dn); end
        n_checks++;
        if (dn_k !== 26) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 26", dn_k); end
        n_checks++;
        if (h_prev !== {H{15'd3}}) begin n_fail++; $display("FAIL basic_h_prev: got %h expected %h", h_prev, {H{15'd3}}); end
        n_checks++;
        if (step_idx !== T_W'(2)) begin n_fail++; $display("FAIL basic_step_idx: got %0d expected 2", step_idx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_len0;
        int n_rd = 0, n_st = 0, dn_k = -1;
        seq_len = 0; h_init = {H{15'd7}}; seq_start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            seq_start = 1'b0;
            if (x_rd_en) n_rd++;
            if (cell_start) n_st++;
            if (seq_done && dn_k < 0) dn_k = k;
        end
        n_checks++;
        if (n_rd !== 0) begin n_fail++; $display("FAIL len0_reads: got %0d expected 0", n_rd); end
        n_checks++;
        if (n_st !== 0) begin n_fail++; $display("FAIL len0_starts: got %0d expected 0", n_st); end
        n_checks++;
        if (dn_k !== 2) begin n_fail++; $display("FAIL len0_done_cycle: got %0d expected 2", dn_k); end
        n_checks++;
        if (h_prev !== {H{15'd7}}) begin n_fail++; $display("FAIL len0_h_prev: got %h expected %h", h_prev, {H{15'd7}}); end
    endtask

    task automatic test_back_to_back;
        int n_st = 0, n_dn = 0, dn_k = -1;
        seq_len = 2; h_init = '0; seq_start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            seq_start = (k == 5);
            if (k == 5) seq_len = 5;
            if (cell_start) n_st++;
            if (seq_done) begin n_dn++; dn_k = k; end
        end
        n_checks++;
        if (n_st !== 2) begin n_fail++; $display("FAIL b2b_starts: got %0d expected 2", n_st); end
        n_checks++;
        if (n_dn !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", n_dn); end
        n_checks++;
        if (dn_k !== 18) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected 18", dn_k); end
        n_checks++;
        if (h_prev !== {H{15'd2}}) begin n_fail++; $display("FAIL b2b_h_prev: got %h expected %h", h_prev, {H{15'd2}}); end
    endtask

    task automatic test_spurious;
        int n_rd = 0, n_st = 0, dn_k = -1;
        seq_len = 2; h_init = {H{15'd4}}; seq_start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            seq_start = 1'b0;
            spur = (k == 1 || k == 8 || k == 16);
            if (x_rd_en) n_rd++;
            if (cell_start) n_st++;
            if (seq_done && dn_k < 0) dn_k = k;
        end
        spur = 1'b0;
        n_checks++;
        if (n_rd !== 2) begin n_fail++; $display("FAIL spur_reads: got %0d expected 2", n_rd); end
        n_checks++;
        if (n_st !== 2) begin n_fail++; $display("FAIL spur_starts: got %0d expected 2", n_st); end
        n_checks++;
        if (dn_k !== 18) begin n_fail++; $display("FAIL spur_done_cycle: got %0d expected 18", dn_k); end
        n_checks++;
        if (h_prev !== {H{15'd6}}) begin n_fail++; $display("FAIL spur_h_prev: got %h expected %h", h_prev, {H{15'd6}}); end
    endtask

    task automatic test_reset_mid;
        int n_st = 0, dn_k = -1;
        seq_len = 4; h_init = '0; seq_start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            seq_start = 1'b0;
        end
        n_checks++;
        if (step_idx !== T_W'(1)) begin n_fail++; $display("FAIL mid_step_before: got %0d expected 1", step_idx); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({x_rd_en, cell_start, busy, seq_done, seq_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: got %b expected 00000", {x_rd_en, cell_start, busy, seq_done, seq_err});
        end
        n_checks++;
        if (h_prev !== '0) begin n_fail++; $display("FAIL mid_reset_h_prev: got %h expected 0", h_prev); end
        n_checks++;
        if (step_idx !== '0) begin n_fail++; $display("FAIL mid_reset_step_idx: got %0d expected 0", step_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        seq_len = 1; h_init = {H{15'd5}}; seq_start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            seq_start = 1'b0;
            if (cell_start) n_st++;
            if (seq_done && dn_k < 0) dn_k = k;
        end
        n_checks++;
        if (n_st !== 1) begin n_fail++; $display("FAIL mid_rerun_starts: got %0d expected 1", n_st); end
        n_checks++;
        if (dn_k !== 10) begin n_fail++; $display("FAIL mid_rerun_done_cycle: got %0d expected 10", dn_k); end
        n_checks++;
        if (h_prev !== {H{15'd6}}) begin n_fail++; $display("FAIL mid_rerun_h_prev: got %h expected %h", h_prev, {H{15'd6}}); end
    endtask

    task automatic test_wdog;
        int n_idle = 0, n_err = 0, err_k = -1, n_dn = 0;
        cell_en = 1'b0; seq_len = 1; h_init = {H{15'd9}}; seq_start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            seq_start = 1'b0;
            if (!busy) n_idle++;
            if (seq_err) begin n_err++; if (err_k < 0) err_k = k; end
            if (seq_done) n_dn++;
        end
`ifdef GRU_SEQ_WDOG_EN
        n_checks++;
        if (err_k !== 18) begin n_fail++; $display("FAIL wdog_err_cycle: got %0d expected 18", err_k); end
        n_checks++;
        if (n_err !== 1) begin n_fail++; $display("FAIL wdog_err_count: got %0d expected 1", n_err); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wdog_busy: got %b expected 0", busy); end
        n_checks++;
        if (h_prev !== {H{15'd9}}) begin n_fail++; $display("FAIL wdog_h_prev: got %h expected %h", h_prev, {H{15'd9}}); end
`else
        n_checks++;
        if (n_idle !== 0) begin n_fail++; $display("FAIL nowdog_busy: got %0d idle cycles expected 0", n_idle); end
        n_checks++;
        if (n_err !== 0) begin n_fail++; $display("FAIL nowdog_err: got %0d pulses expected 0", n_err); end
`endif
        n_checks++;
        if (n_dn !== 0) begin n_fail++; $display("FAIL hang_done: got %0d pulses expected 0", n_dn); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cell_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_len0;
        test_back_to_back;
        test_spurious;
        test_reset_mid;
        test_wdog;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gru_seq_controller.md
Name: gru_seq_controller

Overview:
- Sequences a single gru_cell_parallel instance over an input sequence of up to MAX_T timesteps.
- Per step: fetches x_t from an external feature buffer with 1-cycle read latency, holds the hidden state and feeds it back as h_t_prev, and pulses the cell's start.
- On each cell done, captures h_t.
- Sits between the host/DMA and the GRU datapath; weights and biases are wired to the cell directly and are not touched here.

Parameters:
- H, 16, hidden units
- DATA_WIDTH, 15, fixed-point word width (Q5.9 at FRAC_BITS=9)
- MAX_T, 32, maximum sequence length
- T_W, $clog2(MAX_T+1), width of length/step fields
- WDOG_CYCLES, 1024, watchdog limit per step (optional feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- seq_start  in  1  start request; sampled only in IDLE
- seq_len  in  T_W  number of timesteps, latched on accepted seq_start
- h_init  in  H*DATA_WIDTH  initial hidden state, latched on accepted seq_start; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- x_rd_en  out  1  feature buffer read strobe
- x_rd_addr  out  T_W  timestep index; held stable from FETCH through WAIT
- cell_start  out  1  1-cycle start pulse to the cell
- cell_done  in  1  1-cycle done pulse from the cell
- cell_h_t  in  H*DATA_WIDTH  cell output h_t, valid when cell_done=1
- h_prev  out  H*DATA_WIDTH  hidden-state register driving cell h_t_prev
- step_idx  out  T_W  current timestep
- busy  out  1  high in any state except IDLE
- seq_done  out  1  1-cycle pulse at sequence completion
- seq_err  out  1  1-cycle pulse on watchdog abort (0 when feature compiled out)

Behaviour:
- Reset, asynchronous: state=IDLE.
  - All registered outputs are 0: x_rd_en, x_rd_addr, cell_start, h_prev, step_idx, busy, seq_done, seq_err.
  - Latched length is 0.
  - Reset mid-sequence discards all progress; the cell is expected to be reset by the same rst_n.
- All outputs are registered.
- States: IDLE, FETCH, START, WAIT, UPDATE, FINISH.
- IDLE:
  - seq_start=1 with seq_len==0: h_prev<=h_init, then go to FINISH. seq_done pulses 2 cycles after seq_start.
  - seq_start=1 with seq_len>seq_len clipped: seq_len>MAX_T is saturated to MAX_T.
  - seq_start=1 otherwise: h_prev<=h_init, step_idx<=0, go to FETCH.
- FETCH: x_rd_en=1 and x_rd_addr=step_idx for exactly 1 cycle, then START. Buffer data is valid the following cycle and is held by the buffer until the next read.
- START: cell_start=1 for exactly 1 cycle, then WAIT.
- WAIT:
  - Hold until cell_done=1, then UPDATE.
  - On that same edge, register cell_h_t into a staging register.
- UPDATE:
  - h_prev<=staged h_t.
  - If step_idx==len-1, go to FINISH.
  - Otherwise step_idx<=step_idx+1 and go to FETCH.
  - Per-step overhead is 3 cycles plus cell latency.
- FINISH: seq_done=1 for 1 cycle, then IDLE. h_prev holds the final hidden state until the next accepted seq_start.
- Handshake and edge rules:
  - seq_start while busy is ignored, not queued.
  - cell_done outside WAIT is ignored.
  - cell_start is never reasserted before the matching cell_done.
  - cell_done arriving in the same cycle as entry to WAIT (zero-latency cell) is accepted.
- Width rules:
  - step_idx never exceeds MAX_T-1; no wrap-around.
  - h_prev is a plain register copy; no arithmetic and no saturation in this block.

Optional Feature:
- Macro: GRU_SEQ_WDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches WDOG_CYCLES without cell_done, seq_err pulses 1 cycle and the FSM returns to IDLE.
  - h_prev and step_idx retain their values at the abort; seq_done is not pulsed.
- Undefined: the counter is absent, WAIT waits indefinitely, and seq_err is tied to 0.

Test Plan:
- Reset, then seq_start with seq_len=3 and a fake cell returning cell_h_t = h_prev+1 per word after 5 cycles, h_init=0.
  - x_rd_addr sequence is 0,1,2.
  - Exactly 3 cell_start pulses.
  - Final h_prev words are all 3.
  - seq_done pulses once, 3*(3+5)+2 cycles after seq_start.
- seq_len=0, h_init words = 7 -> no x_rd_en, no cell_start; seq_done 2 cycles after seq_start; h_prev words = 7.
- seq_start pulsed again during WAIT of a seq_len=2 run -> ignored; exactly 2 steps run; latched length is unchanged.
- Spurious cell_done injected in FETCH and UPDATE -> no state change; h_prev is updated only by the cell_done seen in WAIT.
- rst_n asserted mid-WAIT at step 1 of 4 -> all outputs 0 asynchronously; a fresh seq_len=1 run afterwards completes normally.
- With GRU_SEQ_WDOG_EN and WDOG_CYCLES=16, cell never returns done:
  - seq_err pulses 16 cycles after cell_start.
  - FSM goes to IDLE with busy=0 and no seq_done.
- Without the macro: busy stays 1 indefinitely.
